// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
// Shared definitions for the UART command framing path (RX framer today, TX
// side later).
//
// Contents:
//   - command codes understood by the badge dispatcher
//   - frame lengths (long frame and the 3-byte short frame)
//   - framer state encoding
//   - sat_inc8: saturating 8-bit increment used by the error counters
//
// No ports (package).
// -----------------------------------------------------------------------------
package uart_frame_pkg;

    // Command codes. The accepted command window is CMD_SEND_TX..CMD_AES_PT.
    localparam logic [7:0] CMD_SEND_TX        = 8'd64;  // "@"
    localparam logic [7:0] CMD_SHOOTING_FLAGS = 8'd65;  // "A", uses the short frame
    localparam logic [7:0] CMD_AES_KEY        = 8'd66;  // "B"
    localparam logic [7:0] CMD_AES_PT         = 8'd67;  // "C"

    // Long frame: cmd + 16 payload bytes + delimiter.
    localparam int FRAME_BYTES       = 18;
    // Short frame: cmd + arg + delimiter.
    localparam int SHORT_FRAME_BYTES = 3;

    // Framer state encoding.
    //   ST_IDLE    : waiting for a command byte
    //   ST_COLLECT : gathering payload bytes, then the delimiter
    //   ST_EMIT    : one cycle in which the validated frame is published
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } frame_state_t;

    // Saturating increment: sticks at 255 instead of wrapping to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end
        return value + 8'd1;
    endfunction

endpackage

// File: rtl/frame_timeout_timer.sv
// -----------------------------------------------------------------------------
// frame_timeout_timer
// Inter-byte watchdog for a UART framer. Loaded whenever a byte is accepted,
// decremented on every enabled cycle, and reports expiry when the count has
// run down to zero while enabled.
//
// Timing: after a load in cycle 0 the count reads TIMEOUT_CYCLES-1 in cycle 1
// and reaches 0 in cycle TIMEOUT_CYCLES, so 'expired' is asserted exactly
// TIMEOUT_CYCLES cycles after the loading byte. A load in that same cycle
// restarts the window (the owner decides that a fresh byte wins).
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles allowed between two loads
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset (count cleared)
//   load     in   restart the window
//   en       in   count down this cycle (owner is waiting for a byte)
//   expired  out  window elapsed with no load (only while en)
// -----------------------------------------------------------------------------
module frame_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1_033_400
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    // The count only ever holds values 0..TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign expired = en && (count == '0);

endmodule

// File: rtl/uart_cmd_framer.sv
// -----------------------------------------------------------------------------
// uart_cmd_framer
// Turns the UART RX byte stream into validated command frames for the badge
// command dispatcher. A frame starts with a command byte in CMD_MIN..CMD_MAX,
// carries either one argument byte (SHORT_CMD) or FRAME_BYTES-2 payload bytes,
// and ends with a delimiter equal to the command byte. Frames with a wrong
// delimiter or an inter-byte gap longer than TIMEOUT_CYCLES are discarded, so
// nothing partial or garbled reaches the challenge logic.
//
// Build option:
//   UART_FRAMER_ERR_CNT_EN  when defined, err_delim / err_timeout / err_cmd are
//                           live saturating counters; when undefined the
//                           counters are not built and the ports read 0.
//                           Framing is identical in both builds.
//
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   rx_valid       in   one-cycle strobe: rx_byte holds a new byte
//   rx_byte        in   received byte
//   frame_valid    out  one-cycle strobe: frame_* were updated this cycle
//   frame_cmd      out  command byte of the last good frame
//   frame_arg      out  first byte after the command
//   frame_payload  out  payload bytes 1..16, byte 1 in the top byte lane;
//                       short frames give {arg, zeros}
//   frame_short    out  last good frame was a 3-byte frame
//   busy           out  a frame is being collected or emitted
//   err_delim      out  saturating count of delimiter mismatches
//   err_timeout    out  saturating count of inter-byte timeouts
//   err_cmd        out  saturating count of bytes rejected while idle
//
// Handshake: rx_valid is a strobe with no backpressure; every byte presented
// with rx_valid high is consumed in that cycle. frame_valid is likewise a
// one-cycle strobe; frame_* hold their value until the next good frame.
// -----------------------------------------------------------------------------
module uart_cmd_framer
    import uart_frame_pkg::*;
#(
    parameter int DBITS          = 8,
    parameter int FRAME_BYTES    = uart_frame_pkg::FRAME_BYTES,
    parameter int SHORT_CMD      = 65,
    parameter int CMD_MIN        = 64,
    parameter int CMD_MAX        = 67,
    parameter int TIMEOUT_CYCLES = 1_033_400
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             rx_valid,
    input  logic [DBITS-1:0]                 rx_byte,
    output logic                             frame_valid,
    output logic [DBITS-1:0]                 frame_cmd,
    output logic [DBITS-1:0]                 frame_arg,
    output logic [(FRAME_BYTES-2)*DBITS-1:0] frame_payload,
    output logic                             frame_short,
    output logic                             busy,
    output logic [7:0]                       err_delim,
    output logic [7:0]                       err_timeout,
    output logic [7:0]                       err_cmd
);

    localparam int PAY_BYTES = FRAME_BYTES - 2;
    localparam int PAY_W     = PAY_BYTES * DBITS;
    localparam int IDX_W     = $clog2(FRAME_BYTES + 1);

    localparam logic [DBITS-1:0] CMD_MIN_B   = DBITS'(CMD_MIN);
    localparam logic [DBITS-1:0] CMD_MAX_B   = DBITS'(CMD_MAX);
    localparam logic [DBITS-1:0] SHORT_CMD_B = DBITS'(SHORT_CMD);
    localparam logic [IDX_W-1:0] LEN_LONG    = IDX_W'(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LEN_SHORT   = IDX_W'(SHORT_FRAME_BYTES);

    // ------------------------------------------------------------------
    // State and frame-in-progress registers
    // ------------------------------------------------------------------
    frame_state_t     state;
    frame_state_t     next_state;

    logic [DBITS-1:0] cmd_q;    // command of the frame being collected
    logic [DBITS-1:0] arg_q;    // byte at position 1
    logic [PAY_W-1:0] pay_q;    // payload bytes, shifted in from the bottom
    logic [IDX_W-1:0] len_q;    // expected frame length in bytes
    logic [IDX_W-1:0] idx_q;    // position of the next byte within the frame
    logic             short_q;  // frame being collected is a short frame

    // ------------------------------------------------------------------
    // FSM control strobes (decoded in the next-state process)
    // ------------------------------------------------------------------
    logic accept_cmd;   // idle-side byte is a valid command: open a frame
    logic reject_cmd;   // idle-side byte is not a command: drop it
    logic store_byte;   // body byte stored at position idx
    logic delim_bad;    // delimiter position held the wrong byte
    logic timed_out;    // inter-byte window elapsed
    logic emit;         // publish the collected frame this cycle

    logic byte_is_cmd;
    logic byte_is_short;
    logic at_delim;
    logic tmr_expired;

    assign byte_is_cmd   = (rx_byte >= CMD_MIN_B) && (rx_byte <= CMD_MAX_B);
    assign byte_is_short = (rx_byte == SHORT_CMD_B);
    assign at_delim      = (idx_q == (len_q - IDX_W'(1)));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode
    always_comb begin
        next_state = state;
        accept_cmd = 1'b0;
        reject_cmd = 1'b0;
        store_byte = 1'b0;
        delim_bad  = 1'b0;
        timed_out  = 1'b0;
        emit       = 1'b0;

        case (state)
            // EMIT lasts one cycle and then behaves exactly like IDLE for any
            // byte arriving alongside it, so a command that follows a
            // delimiter back-to-back is not lost.
            ST_IDLE, ST_EMIT: begin
                emit       = (state == ST_EMIT);
                next_state = ST_IDLE;
                if (rx_valid) begin
                    if (byte_is_cmd) begin
                        accept_cmd = 1'b1;
                        next_state = ST_COLLECT;
                    end else begin
                        reject_cmd = 1'b1;
                    end
                end
            end

            ST_COLLECT: begin
                // A byte in the expiry cycle wins over the timeout.
                if (rx_valid) begin
                    if (at_delim) begin
                        // A bad delimiter is consumed here; it is never
                        // re-examined as the start of a new frame.
                        if (rx_byte == cmd_q) begin
                            next_state = ST_EMIT;
                        end else begin
                            delim_bad  = 1'b1;
                            next_state = ST_IDLE;
                        end
                    end else begin
                        store_byte = 1'b1;
                    end
                end else if (tmr_expired) begin
                    timed_out  = 1'b1;
                    next_state = ST_IDLE;
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Inter-byte watchdog
    // ------------------------------------------------------------------
    frame_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept_cmd || store_byte),
        .en      (state == ST_COLLECT),
        .expired (tmr_expired)
    );

    // ------------------------------------------------------------------
    // Frame assembly and output word
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q         <= '0;
            arg_q         <= '0;
            pay_q         <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            short_q       <= 1'b0;
            frame_valid   <= 1'b0;
            frame_cmd     <= '0;
            frame_arg     <= '0;
            frame_payload <= '0;
            frame_short   <= 1'b0;
        end else begin
            frame_valid <= emit;

            // Publish from the collected registers; an accept_cmd in the same
            // cycle overwrites them only after this read.
            if (emit) begin
                frame_cmd   <= cmd_q;
                frame_arg   <= arg_q;
                frame_short <= short_q;
                if (short_q) begin
                    frame_payload <= {arg_q, {(PAY_W - DBITS){1'b0}}};
                end else begin
                    frame_payload <= pay_q;
                end
            end

            if (accept_cmd) begin
                cmd_q   <= rx_byte;
                short_q <= byte_is_short;
                len_q   <= byte_is_short ? LEN_SHORT : LEN_LONG;
                idx_q   <= IDX_W'(1);
                pay_q   <= '0;
            end else if (store_byte) begin
                idx_q <= idx_q + IDX_W'(1);
                // After PAY_BYTES shifts, byte 1 sits in the top lane.
                pay_q <= {pay_q[PAY_W-DBITS-1:0], rx_byte};
                if (idx_q == IDX_W'(1)) begin
                    arg_q <= rx_byte;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Error counters
    // ------------------------------------------------------------------
`ifdef UART_FRAMER_ERR_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_delim   <= 8'd0;
            err_timeout <= 8'd0;
            err_cmd     <= 8'd0;
        end else begin
            if (delim_bad) begin
                err_delim <= sat_inc8(err_delim);
            end
            if (timed_out) begin
                err_timeout <= sat_inc8(err_timeout);
            end
            if (reject_cmd) begin
                err_cmd <= sat_inc8(err_cmd);
            end
        end
    end
`else
    // Error strobes still decode the framing; only the counting is absent.
    logic unused_err_strobes;
    assign unused_err_strobes = ^{delim_bad, timed_out, reject_cmd};

    assign err_delim   = 8'd0;
    assign err_timeout = 8'd0;
    assign err_cmd     = 8'd0;
`endif

endmodule

// File: tb/tb_uart_cmd_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_framer
// Directed bench for uart_cmd_framer with a short inter-byte timeout. Good
// frames are pushed to an expected queue as they are sent; a negedge monitor
// pops and compares every frame_valid. Error counters are expected live when
// UART_FRAMER_ERR_CNT_EN is defined and zero otherwise.
// -----------------------------------------------------------------------------
module tb_uart_cmd_framer;

    localparam int TO = 100;
    localparam int W  = 8 + 8 + 128 + 1;   // {cmd, arg, payload, short}

`ifdef UART_FRAMER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset_n;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         frame_valid;
    logic [7:0]   frame_cmd;
    logic [7:0]   frame_arg;
    logic [127:0] frame_payload;
    logic         frame_short;
    logic         busy;
    logic [7:0]   err_delim;
    logic [7:0]   err_timeout;
    logic [7:0]   err_cmd;

    always #5 clk = ~clk;

    uart_cmd_framer #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .frame_valid   (frame_valid),
        .frame_cmd     (frame_cmd),
        .frame_arg     (frame_arg),
        .frame_payload (frame_payload),
        .frame_short   (frame_short),
        .busy          (busy),
        .err_delim     (err_delim),
        .err_timeout   (err_timeout),
        .err_cmd       (err_cmd)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_good = '0;
    int n_checks   = 0;
    int n_pass     = 0;
    int n_fail     = 0;
    int n_expected = 0;
    int n_frames   = 0;

    logic [7:0] pl [16];

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cnt_exp(input int n);
        int sat;
        sat = (n > 255) ? 255 : n;
        return CNT_EN ? 8'(sat) : 8'd0;
    endfunction

    task automatic push_exp(input logic [7:0] c, input logic [7:0] a,
                            input logic [127:0] p, input logic s);
        exp_q.push_back({c, a, p, s});
        last_good = {c, a, p, s};
        n_expected++;
    endtask

    // Monitor: every frame strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && frame_valid === 1'b1) begin
            n_frames++;
            n_checks++;
            assert (exp_q.size() > 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL frame_unexpected: observed frame cmd %0h with empty queue, required no frame",
                       frame_cmd);
            end
            if (exp_q.size() > 0) begin
                check("frame_word", {frame_cmd, frame_arg, frame_payload, frame_short},
                      exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom_range(0, 255));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap();
        idle($urandom_range(0, 3));
    endtask

    function automatic logic [127:0] pl_word();
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) p[127-8*i -: 8] = pl[i];
        return p;
    endfunction

    // Long frame from pl[]; expected only when the delimiter matches.
    task automatic send_long(input logic [7:0] cmd, input logic [7:0] delim);
        send(cmd);
        gap();
        for (int i = 0; i < 16; i++) begin
            send(pl[i]);
            gap();
        end
        if (delim == cmd) push_exp(cmd, pl[0], pl_word(), 1'b0);
        send(delim);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"},   frame_valid,   0);
        check({tag, "_cmd"},     frame_cmd,     0);
        check({tag, "_arg"},     frame_arg,     0);
        check({tag, "_payload"}, frame_payload, 0);
        check({tag, "_short"},   frame_short,   0);
        check({tag, "_busy"},    busy,          0);
        check({tag, "_edelim"},  err_delim,     0);
        check({tag, "_etmo"},    err_timeout,   0);
        check({tag, "_ecmd"},    err_cmd,       0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;

        // Reset state
        idle(3);
        @(negedge clk);
        check_outputs_zero("reset");
        idle(1);
        reset_n = 1'b1;
        idle(2);

        // Short frame 41 43 41, with latency check on the delimiter
        send(8'h41); gap();
        send(8'h43); gap();
        push_exp(8'h41, 8'h43, {8'h43, 120'b0}, 1'b1);
        send(8'h41);
        @(negedge clk);
        check("short_lat_edge1_valid", frame_valid, 0);
        check("short_lat_edge1_busy",  busy, 1);
        idle(1);
        @(negedge clk);
        check("short_lat_edge2_valid", frame_valid, 1);
        idle(1);
        @(negedge clk);
        check("short_after_valid", frame_valid, 0);
        check("short_after_busy",  busy, 0);

        // Long frame 42, 00..0F, 42
        for (int i = 0; i < 16; i++) pl[i] = 8'(i);
        send_long(8'h42, 8'h42);
        idle(3);
        @(negedge clk);
        check("long_busy_after", busy, 0);
        check("long_payload_hold", frame_payload, 128'h000102030405060708090A0B0C0D0E0F);
        check("long_ecmd", err_cmd, cnt_exp(0));

        // Back-to-back: second command arrives in the EMIT cycle
        push_exp(8'h41, 8'h43, {8'h43, 120'b0}, 1'b1);
        send(8'h41); send(8'h43); send(8'h41);
        push_exp(8'h41, 8'h44, {8'h44, 120'b0}, 1'b1);
        send(8'h41); send(8'h44); send(8'h41);
        idle(3);
        @(negedge clk);
        check("b2b_busy", busy, 0);
        check("b2b_ecmd", err_cmd, cnt_exp(0));

        // Bad delimiter: outputs must hold the last good frame
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
        send_long(8'h43, 8'h44);
        idle(3);
        @(negedge clk);
        check("bad_delim_count", err_delim, cnt_exp(1));
        check("bad_delim_hold", {frame_cmd, frame_arg, frame_payload, frame_short}, last_good);
        check("bad_delim_busy", busy, 0);
        send(8'h41); gap();
        send(8'h42); gap();
        push_exp(8'h41, 8'h42, {8'h42, 120'b0}, 1'b1);
        send(8'h41);
        idle(3);

        // Bad delimiter that is itself a valid command must not open a frame
        send_long(8'h42, 8'h41);
        @(negedge clk);
        check("bad_delim_cmd_busy", busy, 0);
        check("bad_delim_cmd_count", err_delim, cnt_exp(2));
        check("bad_delim_cmd_ecmd", err_cmd, cnt_exp(0));
        idle(2);

        // Timeout: 42 + 5 bytes then silence
        send(8'h42);
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
        idle(TO - 1);
        @(negedge clk);
        check("timeout_edge_busy", busy, 1);
        idle(1);
        @(negedge clk);
        check("timeout_busy", busy, 0);
        check("timeout_count", err_timeout, cnt_exp(1));
        idle(2);

        // Byte in the expiry cycle keeps the frame alive; an in-payload 42 is data
        for (int i = 0; i < 16; i++) pl[i] = 8'(8'h20 + i);
        pl[9] = 8'h42;
        send(8'h42);
        for (int i = 0; i < 5; i++) send(pl[i]);
        idle(TO - 1);
        send(pl[5]);
        @(negedge clk);
        check("keepalive_busy", busy, 1);
        for (int i = 6; i < 16; i++) send(pl[i]);
        push_exp(8'h42, pl[0], pl_word(), 1'b0);
        send(8'h42);
        idle(3);
        @(negedge clk);
        check("keepalive_etmo", err_timeout, cnt_exp(1));
        check("keepalive_busy_after", busy, 0);

        // Garbage and saturation
        repeat (300) send(8'h5A);
        idle(2);
        @(negedge clk);
        check("garbage_ecmd", err_cmd, cnt_exp(300));
        check("garbage_busy", busy, 0);

        // Reset mid-frame
        send(8'h42);
        for (int i = 0; i < 7; i++) send(8'(8'h60 + i));
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        idle(2);
        reset_n = 1'b1;
        idle(2);
        send(8'h41); gap();
        send(8'h4D); gap();
        push_exp(8'h41, 8'h4D, {8'h4D, 120'b0}, 1'b1);
        send(8'h41);
        idle(4);
        @(negedge clk);
        check("post_reset_busy", busy, 0);

        // Final report
        check("queue_drained", exp_q.size(), 0);
        check("frame_count", n_frames, n_expected);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
- Sits between the UART receiver byte stream and the badge command dispatcher.
- Assembles delimited command frames and checks the end-delimiter, length and inter-byte timeout.
- Presents each validated frame as one parallel word plus a single-cycle strobe.
- Replaces ad-hoc matching on the raw shift-register window, so partial or garbled frames never reach challenge logic.

Parameters:
- DBITS, 8, bits per UART byte.
- FRAME_BYTES, 18, long-frame length: cmd, 16 payload bytes, delimiter.
- SHORT_CMD, 65 ("A"), command code using a 3-byte frame: cmd, arg, delimiter.
- CMD_MIN, 64 ("@"), lowest accepted command code.
- CMD_MAX, 67 ("C"), highest accepted command code.
- TIMEOUT_CYCLES, 1_033_400, idle cycles allowed between bytes inside a frame (10 ms at 103.34 MHz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_byte holds a new received byte.
- rx_byte  in  8  received byte.
- frame_valid  out  1  one-cycle strobe: frame outputs were updated this cycle.
- frame_cmd  out  8  command byte of the last good frame.
- frame_arg  out  8  first byte after cmd.
- frame_payload  out  128  bytes 1..16, byte 1 at [127:120].
- frame_short  out  1  last good frame was a 3-byte frame.
- busy  out  1  a frame is being collected.
- err_delim  out  8  saturating count of delimiter mismatches.
- err_timeout  out  8  saturating count of inter-byte timeouts.
- err_cmd  out  8  saturating count of bytes rejected in IDLE.

Behaviour:
- Reset: all outputs 0. State IDLE, byte index 0, timer 0.
- IDLE state:
  - rx_valid with rx_byte in [CMD_MIN, CMD_MAX]: latch cmd, set expected length (3 if cmd==SHORT_CMD, else FRAME_BYTES), idx=1, load timer, go COLLECT.
  - Any other byte: discard, err_cmd++.
- COLLECT state, on each rx_valid:
  - If idx < len-1: store the byte at position idx, idx++, reload timer.
  - If idx == len-1: this is the delimiter. Delimiter==cmd: go EMIT. Otherwise err_delim++ and go IDLE; that byte is NOT re-evaluated as a new cmd.
- EMIT state (one cycle):
  - Update frame_cmd, frame_arg, frame_payload, frame_short together and pulse frame_valid=1.
  - Return to IDLE.
  - Latency: frame_valid is high the 2nd clk edge after the delimiter's rx_valid cycle.
  - An rx_valid arriving during EMIT is handled as IDLE input (cmd check) in the same cycle; no byte is dropped.
- Short frames: frame_payload = {arg, 120'b0}.
- Outputs hold their value until the next good frame; they are never cleared by errors.
- busy = (state != IDLE).
- Timer:
  - Decrements every cycle in COLLECT.
  - Reaching 0 with no rx_valid: err_timeout++, go IDLE, discard the partial frame.
  - rx_valid in the same cycle the timer hits 0: the byte wins; it is processed and the timer reloads.
- Error counters: saturate at 255 and never wrap.
- Delimiter bytes equal to a valid cmd inside a payload are plain data; only position len-1 is checked.
- Async reset mid-frame: immediate return to IDLE and a zeroed output word; no frame_valid.

Optional Feature:
- UART_FRAMER_ERR_CNT_EN
  - Defined: err_delim, err_timeout and err_cmd behave as above.
  - Undefined: the counters and their logic are removed, and the three ports are tied to 8'd0.
  - Framing behaviour is identical either way.

Decomposition:
- Package/include uart_frame_pkg:
  - CMD_SEND_TX=64, CMD_SHOOTING_FLAGS=65, CMD_AES_KEY=66, CMD_AES_PT=67.
  - FRAME_BYTES and SHORT_FRAME_BYTES=3.
  - State encoding IDLE/COLLECT/EMIT.
  - Saturating-increment helper function.
- One sub-module, frame_timeout_timer: load/decrement/expire counter parameterised by TIMEOUT_CYCLES. Reused by the TX side later.

Test Plan:
- Short frame: bytes 41 43 41 → one frame_valid, frame_cmd=8'h41, frame_arg=8'h43, frame_short=1, frame_payload=128'h43<<120.
- Long frame: 42, bytes 00..0F, 42 → frame_valid once, frame_payload=128'h000102..0F, frame_short=0, busy low after EMIT.
- Bad delimiter: 43, 16 bytes, 44 → no frame_valid, err_delim=1, prior frame outputs unchanged. A following good "A","B","A" frame is accepted.
- Timeout: 42 then 5 bytes, silence of TIMEOUT_CYCLES (set to 100 in the bench) → err_timeout=1, busy=0. A byte at exactly cycle 100 instead keeps the frame alive.
- Garbage and saturation: 300 bytes of 8'h5A in IDLE → err_cmd=255, no frame_valid. Same run with the macro undefined → err_cmd=0.
- Reset mid-frame: reset_n low after 8 bytes of a long frame → all outputs 0, busy=0. The next complete frame is accepted normally.
